// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory bus arbiter: FSM encodings, requester
// indices and the default wait-state timeout.
package mem_bus_arbiter_pkg;

   typedef logic [1:0] bus_state_t;

   localparam bus_state_t BUS_IDLE   = 2'd0;
   localparam bus_state_t BUS_ACCESS = 2'd1;
   localparam bus_state_t BUS_RESP   = 2'd2;

   localparam int REQ_FETCH = 0;
   localparam int REQ_OPND  = 1;
   localparam int REQ_IO    = 2;

   localparam int DEFAULT_TIMEOUT = 15;
   localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts just after last_owner;
// a held lock hands the bus straight back to last_owner.
module rr_arbiter #(
   parameter int NREQ  = 3,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last_owner,
   input  logic             lock_hit,
   output logic [NREQ-1:0]  winner
);

   int idx;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      winner = '0;
      idx    = 0;
      if (lock_hit) begin
         winner[last_owner] = 1'b1;
      end else begin
         // Walk from farthest to nearest so the nearest requester is written last.
         for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(last_owner) + i) % NREQ;
            if (req[idx]) begin
               winner      = '0;
               winner[idx] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises byte transactions from NREQ requesters onto one memory bus with
// round-robin fairness, optional lock and a wait-state timeout.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int BYTE_SIZE = 8,
   parameter int WORD_SIZE = 16,
   parameter int NREQ      = 3,
   parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ-1:0]           lock,
   input  logic [NREQ-1:0]           req_we,
   input  logic [NREQ*WORD_SIZE-1:0] req_addr,
   input  logic [NREQ*BYTE_SIZE-1:0] req_wdata,
   output logic [NREQ-1:0]           gnt,
   output logic [NREQ-1:0]           done,
   output logic [NREQ-1:0]           err,
   output logic [BYTE_SIZE-1:0]      rdata,
   output logic [WORD_SIZE-1:0]      mem_addr,
   output logic                      mem_read_en,
   output logic                      mem_write_en,
   output logic [BYTE_SIZE-1:0]      mem_wdata,
   input  logic [BYTE_SIZE-1:0]      mem_rdata,
   input  logic                      mem_ready
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   bus_state_t       state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] last_owner;
   logic             lock_held;
   logic             err_flag;
   logic [CNT_W-1:0] cnt;

   logic [NREQ-1:0]  winner;
   logic [IDX_W-1:0] win_idx;
   logic             lock_hit;

   assign lock_hit = lock_held & req[last_owner];

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req        (req),
      .last_owner (last_owner),
      .lock_hit   (lock_hit),
      .winner     (winner)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner[i]) win_idx = IDX_W'(i);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= BUS_IDLE;
         owner      <= '0;
         last_owner <= IDX_W'(NREQ - 1);
         lock_held  <= 1'b0;
         err_flag   <= 1'b0;
         cnt        <= '0;
         rdata      <= '0;
      end else begin
         case (state)
            BUS_IDLE: begin
               if (|req) begin
                  owner    <= win_idx;
                  cnt      <= '0;
                  err_flag <= 1'b0;
                  state    <= BUS_ACCESS;
               end
            end
            BUS_ACCESS: begin
               // Ready takes priority even on the final timeout cycle.
               if (mem_ready) begin
                  if (!req_we[owner]) rdata <= mem_rdata;
                  err_flag <= 1'b0;
                  state    <= BUS_RESP;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  err_flag <= 1'b1;
                  state    <= BUS_RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            BUS_RESP: begin
               last_owner <= owner;
               lock_held  <= lock[owner];
               state      <= BUS_IDLE;
            end
            default: state <= BUS_IDLE;
         endcase
      end
   end

   // Outputs decode from registered state, so a reset clears them on the next cycle.
   always_comb begin
      gnt          = '0;
      done         = '0;
      err          = '0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      if (state == BUS_ACCESS || state == BUS_RESP) gnt[owner] = 1'b1;
      if (state == BUS_ACCESS) begin
         mem_addr     = req_addr[int'(owner)*WORD_SIZE +: WORD_SIZE];
         mem_wdata    = req_wdata[int'(owner)*BYTE_SIZE +: BYTE_SIZE];
         mem_write_en = req_we[owner];
         mem_read_en  = ~req_we[owner];
      end
      if (state == BUS_RESP) begin
         if (err_flag) err[owner]  = 1'b1;
         else          done[owner] = 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter and its round-robin picker; inputs change
// and outputs are sampled 1 ns after each rising edge.
module tb_mem_bus_arbiter;

   logic        clk;
   logic        reset;
   logic [2:0]  req, lock, req_we;
   logic [47:0] req_addr;
   logic [23:0] req_wdata;
   logic [2:0]  gnt, done, err;
   logic [7:0]  rdata;
   logic [15:0] mem_addr;
   logic        mem_read_en, mem_write_en;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ready;

   logic [2:0]  rr_req, rr_win;
   logic [1:0]  rr_last;
   logic        rr_lock;

   int checks = 0;
   int errors = 0;

   mem_bus_arbiter #(
      .BYTE_SIZE (8),
      .WORD_SIZE (16),
      .NREQ      (3),
      .TIMEOUT   (15)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .lock         (lock),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .gnt          (gnt),
      .done         (done),
      .err          (err),
      .rdata        (rdata),
      .mem_addr     (mem_addr),
      .mem_read_en  (mem_read_en),
      .mem_write_en (mem_write_en),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready)
   );

   rr_arbiter #(.NREQ(3), .IDX_W(2)) u_rr_tb (
      .req        (rr_req),
      .last_owner (rr_last),
      .lock_hit   (rr_lock),
      .winner     (rr_win)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_addr(input int i, input logic [15:0] a);
      req_addr[i*16 +: 16] = a;
   endtask

   task automatic set_wdata(input int i, input logic [7:0] d);
      req_wdata[i*8 +: 8] = d;
   endtask

   logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

   initial begin
      reset = 1'b1; req = '0; lock = '0; req_we = '0;
      req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
      rr_req = '0; rr_last = '0; rr_lock = 1'b0;

      // Standalone picker vectors
      rr_req = 3'b101; rr_last = 2'd0; rr_lock = 1'b0; #1;
      check("rr_101_last0", rr_win, 3'b100);
      rr_req = 3'b101; rr_last = 2'd2; #1;
      check("rr_101_last2", rr_win, 3'b001);
      rr_req = 3'b011; rr_last = 2'd1; rr_lock = 1'b1; #1;
      check("rr_lock_hit", rr_win, 3'b010);
      rr_req = 3'b011; rr_last = 2'd1; rr_lock = 1'b0; #1;
      check("rr_011_last1", rr_win, 3'b001);
      rr_req = 3'b000; rr_last = 2'd0; #1;
      check("rr_none", rr_win, 3'b000);

      // Reset state
      tick(); tick();
      reset = 1'b0;
      check("rst_gnt", gnt, 3'b000);
      check("rst_done_err", {done, err}, 6'b0);
      check("rst_rdata", rdata, 8'h00);
      check("rst_mem", {mem_addr, mem_wdata, mem_read_en, mem_write_en}, 26'h0);

      // Contention: everyone requesting, memory always ready
      req = 3'b111; mem_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tick();
         check($sformatf("cont_gnt%0d", t), gnt, rr_exp[t]);
         tick();
         check($sformatf("cont_done%0d", t), done, rr_exp[t]);
         tick();
         check($sformatf("cont_idle%0d", t), gnt, 3'b000);
         if (t == 3) req = 3'b000;
      end
      mem_ready = 1'b0;

      // Single fetch read
      set_addr(0, 16'h0010); req = 3'b001;
      tick();
      check("fetch_gnt", gnt, 3'b001);
      check("fetch_strobes", {mem_read_en, mem_write_en}, 2'b10);
      check("fetch_addr", mem_addr, 16'h0010);
      mem_ready = 1'b1; mem_rdata = 8'hA5;
      tick();
      check("fetch_done", done, 3'b001);
      check("fetch_err", err, 3'b000);
      check("fetch_rdata", rdata, 8'hA5);
      check("fetch_resp_strobes", {mem_read_en, mem_write_en}, 2'b00);
      req = 3'b000;
      tick();
      check("fetch_idle_gnt", gnt, 3'b000);

      // Lock: requester 1 keeps the bus for a second transaction
      set_addr(1, 16'h2000); req = 3'b011; lock = 3'b010;
      tick();
      check("lock_gnt_a", gnt, 3'b010);
      tick();
      check("lock_done_a", done, 3'b010);
      tick();
      check("lock_idle_a", gnt, 3'b000);
      tick();
      check("lock_gnt_b", gnt, 3'b010);
      lock = 3'b000;
      tick();
      check("lock_done_b", done, 3'b010);
      tick();
      tick();
      check("lock_gnt_c", gnt, 3'b001);
      tick();
      check("lock_done_c", done, 3'b001);
      req = 3'b000;
      tick();
      mem_ready = 1'b0;

      // Write with one wait state; rdata must not change
      set_addr(2, 16'h1234); set_wdata(2, 8'h3C); req_we = 3'b100; req = 3'b100;
      tick();
      check("wr_gnt", gnt, 3'b100);
      check("wr_strobes", {mem_read_en, mem_write_en}, 2'b01);
      check("wr_wdata", mem_wdata, 8'h3C);
      check("wr_addr", mem_addr, 16'h1234);
      tick();
      check("wr_wait_strobes", {mem_read_en, mem_write_en}, 2'b01);
      mem_ready = 1'b1; mem_rdata = 8'h77;
      tick();
      check("wr_done", done, 3'b100);
      check("wr_rdata_held", rdata, 8'hA5);
      req = 3'b000; req_we = 3'b000; mem_ready = 1'b0;
      tick();

      // Timeout: 16 ACCESS cycles without ready
      set_addr(1, 16'h0ABC); req = 3'b010; mem_rdata = 8'h5A;
      tick();
      for (int w = 0; w < 15; w++) tick();
      check("to_last_access_gnt", gnt, 3'b010);
      check("to_last_access_strobe", mem_read_en, 1'b1);
      check("to_last_access_err", err, 3'b000);
      tick();
      check("to_err", err, 3'b010);
      check("to_no_done", done, 3'b000);
      check("to_rdata_held", rdata, 8'hA5);
      req = 3'b000;
      tick();
      check("to_idle_err", err, 3'b000);

      // Ready on the timeout cycle: ready wins
      req = 3'b010;
      tick();
      for (int w = 0; w < 15; w++) tick();
      mem_ready = 1'b1;
      tick();
      check("rdy15_done", done, 3'b010);
      check("rdy15_err", err, 3'b000);
      check("rdy15_rdata", rdata, 8'h5A);
      req = 3'b000; mem_ready = 1'b0;
      tick();

      // Reset in the middle of a waiting access
      req = 3'b100;
      tick();
      check("rstmid_gnt", gnt, 3'b100);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstmid_gnt0", gnt, 3'b000);
      check("rstmid_done_err", {done, err}, 6'b0);
      check("rstmid_rdata", rdata, 8'h00);
      check("rstmid_mem", {mem_addr, mem_read_en, mem_write_en}, 18'h0);
      req = 3'b101;
      tick();
      check("rstmid_first_gnt", gnt, 3'b001);
      mem_ready = 1'b1;
      tick();
      check("rstmid_done", done, 3'b001);
      req = 3'b000; mem_ready = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single external 8-bit memory bus between up to NREQ requesters: instruction fetch, operand read/write and an I/O/DMA port. It sits between the control sequencer's bus requests and the memory interface. It serialises one byte transaction at a time, with round-robin fairness, an optional lock for multi-byte operands, and a wait-state timeout.

## Interface
- BYTE_SIZE, 8, data bus width
- WORD_SIZE, 16, address width
- NREQ, 3, number of requesters; index 0 = fetch, 1 = operand, 2 = I/O
- TIMEOUT, 15, max wait cycles on mem_ready before abort (4-bit counter)
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester transaction request, level
- lock  in  NREQ  keep grant with this requester for its next back-to-back transaction
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*WORD_SIZE  packed addresses, requester i at [i*WORD_SIZE +: WORD_SIZE]
- req_wdata  in  NREQ*BYTE_SIZE  packed write data
- gnt  out  NREQ  one-hot current owner; 0 when idle
- done  out  NREQ  one-cycle completion pulse to the owner
- err  out  NREQ  one-cycle timeout pulse to the owner
- rdata  out  BYTE_SIZE  registered read data
- mem_addr  out  WORD_SIZE  address to memory
- mem_read_en / mem_write_en  out  1 each  strobes
- mem_wdata  out  BYTE_SIZE  write data
- mem_rdata  in  BYTE_SIZE  read data
- mem_ready  in  1  memory completes access this cycle

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req, pick a winner, register it as owner, set gnt, and go to ACCESS; the wait counter clears.
- Winner selection: round-robin starting at (last_owner+1) mod NREQ. If last_owner held lock at its done and still has req set, it wins regardless of the pointer.
- ACCESS: mem_addr and mem_wdata come from the owner's slice, and the strobe follows req_we.
  - If mem_ready: capture mem_rdata into rdata (reads only) and go to RESP.
  - Else if the counter equals TIMEOUT: pulse err[owner] via RESP with error flag, and leave rdata unchanged.
  - Else increment the counter.
- RESP: pulse done[owner] or err[owner] (never both), drop the strobes, update last_owner, and return to IDLE.
- Requesters hold addr, we and wdata stable from req until done/err. Dropping req during ACCESS does not abort the transaction; done still pulses.
- At most one strobe is high at any time. Outside ACCESS, mem_addr = 0 and mem_wdata = 0.

## Timing
- Reset values: state IDLE, gnt 0, done 0, err 0, rdata 0, all mem_* 0, last_owner NREQ-1 (so requester 0 wins first), counter 0.
- Reset mid-transaction: the next cycle is IDLE with all outputs at their reset values. No done/err is issued for the aborted access.
- Minimum latency: req sampled at edge k, gnt and strobe high from k+1, mem_ready at k+1 gives done in cycle k+2. Result: 3 cycles req-to-done-inclusive; each wait state adds 1.
- Timeout: err fires in the cycle after the (TIMEOUT+1)th ACCESS cycle without ready.
- Throughput: one transaction per 3 cycles. IDLE always lasts at least 1 cycle between transactions.
- rdata becomes valid in the done cycle and holds until the next successful read.
- gnt stays high through ACCESS and RESP and drops in IDLE.
- If mem_ready coincides with the timeout cycle, ready wins and done is issued.

## Structure
- Add to global.vh: state encodings `BUS_IDLE`/`BUS_ACCESS`/`BUS_RESP`, requester indices `REQ_FETCH`/`REQ_OPND`/`REQ_IO`, default TIMEOUT.
- Sub-module rr_arbiter: combinational round-robin picker with inputs req, last_owner and lock_hit, and output one-hot winner. It is tested standalone.
- The top level holds the FSM, owner/last_owner registers, wait counter and the address/data muxes.

## Test plan
- Single fetch read: req=001, addr 0x0010, mem_rdata 0xA5, ready on the first ACCESS cycle -> gnt=001 at k+1, done=001 at k+2, rdata=0xA5.
- Contention: req=111 held continuously, always ready -> grants in order 001, 010, 100, 001, each done 3 cycles apart.
- Lock: requester 1 sets lock with req=011 for two transactions -> consecutive grants 010, 010, then 001.
- Wait states and timeout: mem_ready held low with TIMEOUT=15 -> err pulse after 16 ACCESS cycles, no done, rdata unchanged. A second run with ready at wait 15 -> done.
- Write: req_we=1, wdata 0x3C, addr 0x1234 -> mem_write_en=1, mem_wdata=0x3C, mem_addr=0x1234 during ACCESS, mem_read_en=0 throughout.
- Reset in ACCESS: assert reset for 1 cycle mid-wait -> next cycle all outputs 0, no done/err, and the next request is granted to requester 0 first.
